// File: rtl/bt_cmd_link.sv
// Bluetooth command link: parses AA/CMD/ARG/CHK frames from the UART receiver, strobes
// valid commands and paces a 3-byte reply out. Define BT_CMD_CHK_EN to build checksum checking.
module bt_cmd_link #(
  parameter int CLK_FREQ    = 100000000,
  parameter int UART_BPS    = 9600,
  parameter int BYTE_GAP    = (CLK_FREQ/UART_BPS)*11,
  parameter int TIMEOUT_CYC = (CLK_FREQ/UART_BPS)*40
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx_done,
  input  logic [7:0] rx_byte,
  output logic       tx_en,
  output logic [7:0] tx_byte,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       overrun
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_CMD  = 2'd1;
  localparam logic [1:0] R_ARG  = 2'd2;
  localparam logic [1:0] R_CHK  = 2'd3;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_SEND = 2'd1;
  localparam logic [1:0] T_GAP  = 2'd2;

  localparam logic [23:0] L_TIMEOUT  = 24'(TIMEOUT_CYC);
  localparam logic [23:0] L_GAP_END  = 24'(BYTE_GAP - 1);
  localparam logic [23:0] L_SEND_END = 24'd3;

  logic        r_rx_done_q;
  logic [1:0]  r_rx_state;
  logic [23:0] r_idle_cnt;
  logic [7:0]  r_cmd;
  logic [7:0]  r_arg;

  logic [1:0]  r_tx_state;
  logic [1:0]  r_tx_idx;
  logic [23:0] r_tx_cnt;
  logic        r_tx_req;
  logic [7:0]  r_rep_cmd;
  logic [7:0]  r_rep_status;

  logic        w_byte_ev;
  logic        w_frame_done;
  logic        w_tx_busy;
  logic        w_accept;
  logic        w_chk_ok;
  logic [7:0]  w_next_byte;

  assign w_byte_ev    = rx_done & ~r_rx_done_q;
  assign w_frame_done = w_byte_ev && (r_rx_state == R_CHK);
  // A reply queued but not yet started still counts as busy.
  assign w_tx_busy    = r_tx_req || (r_tx_state != T_IDLE);
  assign w_accept     = w_frame_done & ~w_tx_busy;
  assign w_next_byte  = (r_tx_idx == 2'd0) ? r_rep_cmd : r_rep_status;

`ifdef BT_CMD_CHK_EN
  logic [7:0] w_sum;
  assign w_sum    = r_cmd + r_arg;
  assign w_chk_ok = (w_sum == rx_byte);
`else
  assign w_chk_ok = 1'b1;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rx_done_q <= 1'b0;
      r_rx_state  <= R_IDLE;
      r_idle_cnt  <= 24'd0;
      r_cmd       <= 8'h00;
      r_arg       <= 8'h00;
    end else begin
      r_rx_done_q <= rx_done;
      if (w_byte_ev) begin
        r_idle_cnt <= 24'd0;
        case (r_rx_state)
          R_IDLE:  if (rx_byte == 8'hAA) r_rx_state <= R_CMD;
          R_CMD:   begin r_cmd <= rx_byte; r_rx_state <= R_ARG; end
          R_ARG:   begin r_arg <= rx_byte; r_rx_state <= R_CHK; end
          default: r_rx_state <= R_IDLE;
        endcase
      end else if (r_rx_state != R_IDLE) begin
        // A stalled frame is abandoned silently.
        if (r_idle_cnt == L_TIMEOUT) begin
          r_rx_state <= R_IDLE;
          r_idle_cnt <= 24'd0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 24'd1;
        end
      end else begin
        r_idle_cnt <= 24'd0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmd_valid    <= 1'b0;
      cmd_code     <= 8'h00;
      cmd_arg      <= 8'h00;
      overrun      <= 1'b0;
      r_tx_req     <= 1'b0;
      r_rep_cmd    <= 8'h00;
      r_rep_status <= 8'h00;
    end else begin
      cmd_valid <= w_accept & w_chk_ok;
      if (w_accept & w_chk_ok) begin
        cmd_code <= r_cmd;
        cmd_arg  <= r_arg;
      end
      if (w_frame_done & w_tx_busy) overrun <= 1'b1;
      if (w_accept) begin
        r_tx_req     <= 1'b1;
        r_rep_cmd    <= r_cmd;
        r_rep_status <= w_chk_ok ? 8'h00 : 8'h01;
      end else begin
        r_tx_req <= 1'b0;
      end
    end
  end

  // r_tx_cnt counts cycles since the latest tx_en rise.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tx_state <= T_IDLE;
      r_tx_idx   <= 2'd0;
      r_tx_cnt   <= 24'd0;
      tx_en      <= 1'b0;
      tx_byte    <= 8'h00;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (r_tx_req) begin
            r_tx_state <= T_SEND;
            r_tx_idx   <= 2'd0;
            r_tx_cnt   <= 24'd0;
            tx_en      <= 1'b1;
            tx_byte    <= 8'h55;
          end
        end
        T_SEND: begin
          if (r_tx_cnt == L_SEND_END) begin
            tx_en      <= 1'b0;
            r_tx_state <= T_GAP;
          end
          r_tx_cnt <= r_tx_cnt + 24'd1;
        end
        T_GAP: begin
          if (r_tx_cnt == L_GAP_END) begin
            r_tx_cnt <= 24'd0;
            if (r_tx_idx == 2'd2) begin
              r_tx_state <= T_IDLE;
              r_tx_idx   <= 2'd0;
            end else begin
              r_tx_idx   <= r_tx_idx + 2'd1;
              r_tx_state <= T_SEND;
              tx_en      <= 1'b1;
              tx_byte    <= w_next_byte;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 24'd1;
          end
        end
        default: begin
          r_tx_state <= T_IDLE;
          tx_en      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bt_cmd_link.sv
// Self-checking bench for bt_cmd_link: a timeline model of strobes, reply rises and overrun
// is compared against the outputs every cycle, plus literal spot checks on the directed cases.
module tb_bt_cmd_link;

  localparam int CLK_FREQ    = 1000;
  localparam int UART_BPS    = 100;
  localparam int BYTE_GAP    = 110;
  localparam int TIMEOUT_CYC = 400;
`ifdef BT_CMD_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_en;
  logic [7:0] tx_byte;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       overrun;

  bt_cmd_link #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BPS   (UART_BPS),
    .BYTE_GAP   (BYTE_GAP),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx_done  (rx_done),
    .rx_byte  (rx_byte),
    .tx_en    (tx_en),
    .tx_byte  (tx_byte),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .cmd_arg  (cmd_arg),
    .overrun  (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { int c; logic [7:0] b; } rise_t;
  typedef struct { int c; logic [7:0] code; logic [7:0] arg; } strobe_t;

  // Model: when each reply byte request and command strobe must appear.
  rise_t      rises[$];
  strobe_t    strobes[$];
  int         ovrCyc    = -1;
  int         busyUntil = 0;
  int         mState    = 0;
  int         mLastEv   = 0;
  logic [7:0] mCmd      = 8'h00;
  logic [7:0] mArg      = 8'h00;

  int  checks   = 0;
  int  failures = 0;
  bit  modelOn  = 1'b0;
  int  lastE    = 0;
  logic       snapValid, snapEn;
  logic [7:0] snapCode, snapArg, snapByte;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void modelReset(input int n);
    rises.delete();
    strobes.delete();
    ovrCyc    = -1;
    busyUntil = n + 1;
    mState    = 0;
  endfunction

  function automatic void modelFrame(input logic [7:0] chk, input int e);
    logic [7:0] s;
    bit ok;
    s  = mCmd + mArg;
    ok = !CHK_EN || (s == chk);
    if (e < busyUntil) begin
      if (ovrCyc < 0) ovrCyc = e + 1;
      return;
    end
    if (ok) strobes.push_back('{e + 1, mCmd, mArg});
    rises.push_back('{e + 2, 8'h55});
    rises.push_back('{e + 2 + BYTE_GAP, mCmd});
    rises.push_back('{e + 2 + 2*BYTE_GAP, ok ? 8'h00 : 8'h01});
    busyUntil = e + 2 + 3*BYTE_GAP;
  endfunction

  function automatic void modelByte(input logic [7:0] b, input int e);
    if (mState != 0 && (e - mLastEv) > TIMEOUT_CYC + 1) mState = 0;
    mLastEv = e;
    case (mState)
      0:       if (b == 8'hAA) mState = 1;
      1:       begin mCmd = b; mState = 2; end
      2:       begin mArg = b; mState = 3; end
      default: begin mState = 0; modelFrame(b, e); end
    endcase
  endfunction

  always @(negedge sys_clk) begin : cmpBlk
    logic       eEn, eValid, eOvr;
    logic [7:0] eByte, eCode, eArg;
    if (modelOn && !sys_rst) begin
      eEn = 1'b0; eByte = 8'h00; eValid = 1'b0; eCode = 8'h00; eArg = 8'h00;
      foreach (rises[i]) begin
        if (rises[i].c <= cyc) eByte = rises[i].b;
        if (cyc >= rises[i].c && cyc <= rises[i].c + 3) eEn = 1'b1;
      end
      foreach (strobes[i]) begin
        if (strobes[i].c <= cyc) begin
          eCode = strobes[i].code;
          eArg  = strobes[i].arg;
        end
        if (strobes[i].c == cyc) eValid = 1'b1;
      end
      eOvr = (ovrCyc >= 0) && (cyc >= ovrCyc);
      checkOutput("outputs{en,byte,valid,code,arg,ovr}",
                  {5'b0, tx_en, tx_byte, cmd_valid, cmd_code, cmd_arg, overrun},
                  {5'b0, eEn, eByte, eValid, eCode, eArg, eOvr});
    end
  end

  // Sends one byte (rx_done high 5 cycles) and snapshots outputs at E+1 and E+2.
  task automatic applyStimulus(input logic [7:0] b, input int gapAfter);
    @(posedge sys_clk); #1;
    rx_done = 1'b1;
    rx_byte = b;
    lastE   = cyc;
    modelByte(b, cyc);
    @(negedge sys_clk);
    @(negedge sys_clk);
    snapValid = cmd_valid; snapCode = cmd_code; snapArg = cmd_arg;
    @(negedge sys_clk);
    snapEn = tx_en; snapByte = tx_byte;
    repeat (3) @(posedge sys_clk);
    #1 rx_done = 1'b0;
    repeat (gapAfter) @(posedge sys_clk);
  endtask

  task automatic sendFrame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    applyStimulus(8'hAA, 2);
    applyStimulus(c, 2);
    applyStimulus(a, 2);
    applyStimulus(k, 2);
  endtask

  task automatic waitCycle(input int c);
    do @(negedge sys_clk); while (cyc < c);
  endtask

  task automatic doReset();
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    modelReset(cyc);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
  endtask

  initial begin : driver
    int e1, gap, junk;
    logic [7:0] rc, ra, rk;

    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    modelReset(cyc - 1);
    busyUntil = 0;
    modelOn = 1'b1;
    @(negedge sys_clk);
    checkOutput("reset_tx_en", 32'(tx_en), 32'd0);
    checkOutput("reset_tx_byte", 32'(tx_byte), 32'h00);
    checkOutput("reset_cmd", {15'b0, cmd_valid, cmd_code, cmd_arg}, 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);

    $display("[TB] good frame AA 12 34 46");
    sendFrame(8'h12, 8'h34, 8'h46);
    e1 = lastE;
    checkOutput("t1_valid", 32'(snapValid), 32'd1);
    checkOutput("t1_code_arg", {16'b0, snapCode, snapArg}, 32'h1234);
    checkOutput("t1_first_rise", {23'b0, snapEn, snapByte}, 32'h155);
    waitCycle(e1 + 6);
    checkOutput("t1_en_low", 32'(tx_en), 32'd0);
    waitCycle(e1 + 112);
    checkOutput("t1_second", {23'b0, tx_en, tx_byte}, 32'h112);
    waitCycle(e1 + 222);
    checkOutput("t1_third", {23'b0, tx_en, tx_byte}, 32'h100);
    waitCycle(e1 + 2 + 3*BYTE_GAP + 5);

    $display("[TB] bad checksum AA 12 34 47");
    sendFrame(8'h12, 8'h34, 8'h47);
    e1 = lastE;
    checkOutput("t2_valid", 32'(snapValid), CHK_EN ? 32'd0 : 32'd1);
    waitCycle(e1 + 222);
    checkOutput("t2_status", {23'b0, tx_en, tx_byte}, CHK_EN ? 32'h101 : 32'h100);
    waitCycle(e1 + 2 + 3*BYTE_GAP + 5);

    $display("[TB] junk then AA 01 02 03");
    applyStimulus(8'h00, 2);
    applyStimulus(8'hFF, 2);
    sendFrame(8'h01, 8'h02, 8'h03);
    e1 = lastE;
    checkOutput("t3_code_arg", {15'b0, snapValid, snapCode, snapArg}, 32'h10102);
    waitCycle(e1 + 112);
    checkOutput("t3_second", {23'b0, tx_en, tx_byte}, 32'h101);
    waitCycle(e1 + 2 + 3*BYTE_GAP + 5);

    $display("[TB] timeout inside frame");
    applyStimulus(8'hAA, 2);
    applyStimulus(8'h12, 450);
    applyStimulus(8'h34, 2);
    applyStimulus(8'h46, 2);
    checkOutput("t4_no_valid", 32'(snapValid), 32'd0);
    checkOutput("t4_no_tx", 32'(snapEn), 32'd0);
    sendFrame(8'h05, 8'h06, 8'h0B);
    e1 = lastE;
    checkOutput("t4_recover", {15'b0, snapValid, snapCode, snapArg}, 32'h10506);
    waitCycle(e1 + 2 + 3*BYTE_GAP + 5);

    $display("[TB] overrun then reset mid-reply");
    sendFrame(8'h01, 8'h02, 8'h03);
    e1 = lastE;
    waitCycle(e1 + 120);
    sendFrame(8'h07, 8'h08, 8'h0F);
    checkOutput("t5_dropped", {15'b0, snapValid, snapCode, snapArg}, 32'h00102);
    waitCycle(e1 + 180);
    checkOutput("t5_overrun", 32'(overrun), 32'd1);
    doReset();
    @(negedge sys_clk);
    checkOutput("t6_reset", {22'b0, tx_en, tx_byte, overrun}, 32'd0);
    waitCycle(e1 + 222);
    checkOutput("t6_no_third", 32'(tx_en), 32'd0);
    waitCycle(e1 + 600);

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++) begin
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 20));
      rc = 8'($urandom_range(0, 255));
      ra = 8'($urandom_range(0, 255));
      rk = rc + ra;
      if ($urandom_range(0, 3) == 0) rk = rk ^ 8'($urandom_range(1, 255));
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(450, 500) : $urandom_range(0, 40);
      applyStimulus(8'hAA, gap);
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(450, 500) : $urandom_range(0, 40);
      applyStimulus(rc, gap);
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(450, 500) : $urandom_range(0, 40);
      applyStimulus(ra, gap);
      applyStimulus(rk, $urandom_range(0, 400));
      if ($urandom_range(0, 11) == 0) doReset();
    end

    waitCycle(cyc + 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
